// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter in front of a shared FIFO.
// A requester that raises lock together with req keeps the grant for up to MAXB writes.
module fifo_wr_arb #(
  parameter int N = 4,
  parameter int DW = 4,
  parameter int MAXB = 4
) (
  input  logic c,
  input  logic rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lock,
  input  logic [N*DW-1:0] din,
  input  logic full,
  output logic [N-1:0] gnt,
  output logic w,
  output logic [DW-1:0] i,
  output logic busy,
  output logic [2:0] owner
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0] state;
  logic [2:0] last;
  logic [3:0] bcnt;
  logic [2:0] k;
  logic hit;
  logic go;
  int idx;
  // Descending scan so the last match written is the first one after last.
  always_comb begin
    k = owner;
    hit = (state == BURST) & req[owner];
    idx = 0;
    for (int j = N; j >= 1; j--) begin
      idx = (int'(last) + j) % N;
      if (state == IDLE && req[idx]) begin
        hit = 1'b1;
        k = 3'(idx);
      end
    end
  end
  assign go = hit & ~full & rst;
  assign gnt = go ? N'(1) << k : '0;
  assign w = go;
  assign i = go ? din[k*DW +: DW] : '0;
  assign busy = (state == BURST);
  always_ff @(posedge c or negedge rst)
    if (!rst) begin
      state <= IDLE;
      last <= 3'(N-1);
      bcnt <= '0;
      owner <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        last <= k;
        owner <= k;
        if (lock[k] && MAXB > 1) begin
          state <= BURST;
          bcnt <= 4'd1;
        end
      end
    end else if (go) begin
      bcnt <= bcnt + 4'd1;
      if (!lock[owner] || bcnt + 4'd1 == 4'(MAXB)) begin
        state <= IDLE;
        bcnt <= '0;
        last <= owner;
      end
    end else if (!req[owner]) begin
      state <= IDLE;
      bcnt <= '0;
      last <= owner;
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus random traffic against a queue-free
// arbitration model that tracks priority pointer and remaining burst budget.
module tb_fifo_wr_arb;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int MAXB = 4;
  logic c, rst, full, w, busy;
  logic [N-1:0] req, lock, gnt, tg, r;
  logic [N*DW-1:0] din;
  logic [DW-1:0] i;
  logic [2:0] owner;
  int npass, ntot;
  bit mb;
  int ml, mo, mleft, mown;

  fifo_wr_arb #(.N(N), .DW(DW), .MAXB(MAXB)) dut (
    .c(c), .rst(rst), .req(req), .lock(lock), .din(din), .full(full),
    .gnt(gnt), .w(w), .i(i), .busy(busy), .owner(owner)
  );

  initial c = 0;
  always #5 c = ~c;

  task automatic chk(input string t, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", t, got, exp);
  endtask

  function automatic int pick();
    if (!rst || full) return -1;
    if (mb) return req[mo] ? mo : -1;
    for (int s = 1; s <= N; s++)
      if (req[(ml + s) % N]) return (ml + s) % N;
    return -1;
  endfunction

  task automatic upd(input int g);
    if (mb) begin
      if (g >= 0) begin
        mleft--;
        if (!lock[mo] || mleft == 0) begin mb = 0; ml = mo; end
      end else if (!req[mo]) begin
        mb = 0; ml = mo;
      end
    end else if (g >= 0) begin
      ml = g; mown = g;
      if (lock[g] && MAXB > 1) begin mb = 1; mo = g; mleft = MAXB - 1; end
    end
  endtask

  task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lk, input logic f, input int eg);
    int g, ei;
    req = rq; lock = lk; full = f; din = (N*DW)'($urandom);
    #1;
    g = pick();
    ei = 0;
    if (g >= 0) ei = int'(din[g*DW +: DW]);
    chk("gnt", int'(gnt), g < 0 ? 0 : (1 << g));
    chk("w", int'(w), int'(g >= 0));
    chk("i", int'(i), ei);
    chk("busy", int'(busy), int'(mb));
    chk("owner", int'(owner), mown);
    if (eg >= 0) chk("gnt_dir", int'(gnt), eg);
    tg = gnt;
    @(posedge c);
    upd(g);
    @(negedge c);
  endtask

  initial begin
    npass = 0; ntot = 0;
    mb = 0; ml = N - 1; mown = 0; mo = 0; mleft = 0;
    rst = 0; req = '1; lock = '0; full = 0; din = 16'h4321; tg = '0; r = '0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_w", int'(w), 0);
    chk("rst_i", int'(i), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    @(negedge c);
    @(negedge c);
    rst = 1;
    cyc(4'b1111, 4'b0000, 0, 1);
    cyc(4'b1111, 4'b0000, 0, 2);
    cyc(4'b1111, 4'b0000, 0, 4);
    cyc(4'b1111, 4'b0000, 0, 8);
    cyc(4'b1111, 4'b0000, 0, 1);
    for (int n = 0; n < 4; n++) cyc(4'b0101, 4'b0100, 0, 4);
    cyc(4'b0101, 4'b0100, 0, 1);
    cyc(4'b0000, 4'b0000, 0, 0);
    cyc(4'b0010, 4'b0010, 0, 2);
    cyc(4'b0010, 4'b0010, 0, 2);
    for (int n = 0; n < 3; n++) cyc(4'b0010, 4'b0010, 1, 0);
    cyc(4'b0010, 4'b0010, 0, 2);
    cyc(4'b0010, 4'b0010, 0, 2);
    cyc(4'b0000, 4'b0000, 0, 0);
    cyc(4'b1001, 4'b1000, 0, 8);
    cyc(4'b1001, 4'b1000, 0, 8);
    cyc(4'b0001, 4'b1000, 0, 0);
    cyc(4'b0001, 4'b0000, 0, 1);
    cyc(4'b0010, 4'b0010, 0, 2);
    cyc(4'b0010, 4'b0010, 0, 2);
    #3 rst = 0;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_w", int'(w), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_owner", int'(owner), 0);
    mb = 0; ml = N - 1; mown = 0;
    @(posedge c);
    #1 chk("arst_hold_gnt", int'(gnt), 0);
    @(negedge c);
    rst = 1;
    cyc(4'b1000, 4'b0000, 0, 8);
    cyc(4'b1111, 4'b0000, 0, 1);
    r = '0;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < N; k++)
        if (r[k] && !tg[k]) r[k] = $urandom_range(0, 9) != 0;
        else r[k] = $urandom_range(0, 2) == 0;
      cyc(r, N'($urandom), $urandom_range(0, 4) == 0, -1);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
